// File: rtl/pulse_pkg.sv
// Shared types and defaults for the pulse-duration link (encoder and receiver).
package pulse_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } pulse_enc_state_t;

  localparam int DEFAULT_MAX_VALUE  = 8;
  localparam int DEFAULT_GAP_CYCLES = 2;

  // Bits needed to hold 0..max; sizes both the encoder input and receiver output.
  function automatic int value_width(input int max);
    return $clog2(max + 1);
  endfunction

endpackage

// File: rtl/pulse_down_counter.sv
// Loadable down-counter; load wins over dec, is_one flags the terminal count.
module pulse_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             is_one
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec) begin
      count <= count - WIDTH'(1);
    end
  end

  assign is_one = (count == WIDTH'(1));

endmodule

// File: rtl/pulse_encoder.sv
// Value-to-pulse encoder: drives the line high for MAX_VALUE - v cycles, then a guard gap.
// Optional PULSE_ENCODER_RANGE_ERR_EN adds a sticky range_err output for clamped inputs.
//
// state | meaning
// IDLE  | line low, in_ready high, waiting for a value
// PULSE | line high, counter holds remaining high cycles
// GAP   | line low, counter holds remaining guard cycles
module pulse_encoder
  import pulse_pkg::*;
#(
  parameter int MAX_VALUE  = DEFAULT_MAX_VALUE,
  parameter int GAP_CYCLES = DEFAULT_GAP_CYCLES,
  localparam int VW = value_width(MAX_VALUE)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [VW-1:0] in_value,
  output logic          outgoing_line,
  output logic          busy,
  output logic          done
`ifdef PULSE_ENCODER_RANGE_ERR_EN
  ,
  output logic          range_err
`endif
);

  localparam int GW = value_width(GAP_CYCLES);
  localparam int CW = (VW > GW) ? VW : GW;
  localparam logic [VW-1:0] MAX_V    = VW'(MAX_VALUE);
  localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES);

  pulse_enc_state_t state, state_next;
  logic             line_next;
  logic             done_next;
  logic             over_range;
  logic [VW-1:0]    clamped;
  logic [CW-1:0]    duration;
  logic             cnt_load;
  logic [CW-1:0]    cnt_load_value;
  logic             cnt_dec;
  logic [CW-1:0]    cnt;
  logic             cnt_is_one;

  assign over_range = (in_value > MAX_V);
  assign clamped    = over_range ? MAX_V : in_value;
  assign duration   = CW'(MAX_V - clamped);
  assign in_ready   = (state == IDLE);
  assign busy       = (state != IDLE);

  pulse_down_counter #(.WIDTH(CW)) u_counter (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (cnt_load),
    .load_value (cnt_load_value),
    .dec        (cnt_dec),
    .count      (cnt),
    .is_one     (cnt_is_one)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      outgoing_line <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_next;
      outgoing_line <= line_next;
      done          <= done_next;
    end
  end

  always_comb begin
    state_next     = state;
    line_next      = 1'b0;
    done_next      = 1'b0;
    cnt_load       = 1'b0;
    cnt_load_value = '0;
    cnt_dec        = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          cnt_load = 1'b1;
          if (duration != '0) begin
            cnt_load_value = duration;
            state_next     = PULSE;
            line_next      = 1'b1;
          end else begin
            cnt_load_value = GAP_LOAD;
            state_next     = GAP;
            done_next      = 1'b1;
          end
        end
      end
      PULSE: begin
        if (cnt_is_one) begin
          cnt_load       = 1'b1;
          cnt_load_value = GAP_LOAD;
          state_next     = GAP;
          done_next      = 1'b1;
        end else begin
          cnt_dec   = 1'b1;
          line_next = 1'b1;
        end
      end
      GAP: begin
        cnt_dec = (cnt != '0);
        // A zero count also exits, so the gap can never lock the encoder up.
        if (cnt <= CW'(1)) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

`ifdef PULSE_ENCODER_RANGE_ERR_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      range_err <= 1'b0;
    end else if (in_valid && in_ready && over_range) begin
      range_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pulse_encoder.sv
// Self-checking bench for pulse_encoder: schedule-based reference model plus loopback receiver.
module tb_pulse_encoder;
  import pulse_pkg::*;

  localparam int MAXV = 8;
  localparam int GAP  = 2;
  localparam int VW   = value_width(MAXV);

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [VW-1:0] in_value = '0;
  logic          in_ready;
  logic          outgoing_line;
  logic          busy;
  logic          done;
`ifdef PULSE_ENCODER_RANGE_ERR_EN
  logic          range_err;
`endif

  pulse_encoder #(.MAX_VALUE(MAXV), .GAP_CYCLES(GAP)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_value      (in_value),
    .outgoing_line (outgoing_line),
    .busy          (busy),
    .done          (done)
`ifdef PULSE_ENCODER_RANGE_ERR_EN
    ,
    .range_err     (range_err)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: each accepted value is reduced to an edge schedule.
  int ecnt = 0;
  bit have_acc = 1'b0;
  int acc_edge = 0;
  int acc_d = 0;
  int exp_q[$];
  bit exp_rerr = 1'b0;
  int run = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d, t=%0t)", name, act, exp, ecnt, $time);
    end
  endtask

  function automatic int exp_ready(input int e);
    return (!have_acc || e >= acc_edge + acc_d + GAP) ? 1 : 0;
  endfunction

  function automatic int exp_line(input int e);
    return (have_acc && e >= acc_edge && e <= acc_edge + acc_d - 1) ? 1 : 0;
  endfunction

  function automatic int exp_done(input int e);
    return (have_acc && e == acc_edge + acc_d) ? 1 : 0;
  endfunction

  always @(posedge clock) begin
    if (reset_n && in_valid && exp_ready(ecnt) == 1) begin
      int v;
      int c;
      v = int'(in_value);
      c = (v > MAXV) ? MAXV : v;
      have_acc = 1'b1;
      acc_edge = ecnt + 1;
      acc_d    = MAXV - c;
      exp_q.push_back(c);
      if (v > MAXV) exp_rerr = 1'b1;
    end
    ecnt++;
  end

  always @(negedge reset_n) begin
    have_acc = 1'b0;
    exp_q.delete();
    exp_rerr = 1'b0;
    run = 0;
  end

  always @(negedge clock) begin
    check("in_ready", int'(in_ready), exp_ready(ecnt));
    check("line", int'(outgoing_line), exp_line(ecnt));
    check("done", int'(done), exp_done(ecnt));
    check("busy", int'(busy), 1 - exp_ready(ecnt));
`ifdef PULSE_ENCODER_RANGE_ERR_EN
    check("range_err", int'(range_err), int'(exp_rerr));
`endif
    if (reset_n) begin
      if (outgoing_line) run++;
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL decode: got %0d with no encode pending", MAXV - run);
        end else begin
          check("decode", MAXV - run, exp_q.pop_front());
        end
        run = 0;
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input int v);
    int n;
    n = 0;
    while (!in_ready && n < 60) begin
      @(negedge clock);
      n++;
    end
    if (n >= 60) check("send_timeout", 0, 1);
    in_valid = 1'b1;
    in_value = VW'(v);
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic measure(output int width);
    int n;
    width = 0;
    n = 0;
    while (!done && n < 40) begin
      if (outgoing_line) width++;
      @(negedge clock);
      n++;
    end
    if (n >= 40) check("done_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(in_ready && !busy) && n < 60) begin
      @(negedge clock);
      n++;
    end
    if (n >= 60) check("idle_timeout", 0, 1);
    @(negedge clock);
  endtask

  typedef struct {
    int value;
    int width;
    int rerr;
  } vec_t;

  vec_t vecs[8];
  int   seq_vals[3];

  initial begin
    int w;
    vecs[0] = '{value: 3,  width: 5, rerr: 0};
    vecs[1] = '{value: 8,  width: 0, rerr: 0};
    vecs[2] = '{value: 0,  width: 8, rerr: 0};
    vecs[3] = '{value: 12, width: 0, rerr: 1};
    vecs[4] = '{value: 7,  width: 1, rerr: 1};
    vecs[5] = '{value: 1,  width: 7, rerr: 1};
    vecs[6] = '{value: 15, width: 0, rerr: 1};
    vecs[7] = '{value: 9,  width: 0, rerr: 1};
    seq_vals[0] = 5;
    seq_vals[1] = 1;
    seq_vals[2] = 7;

    repeat (2) @(negedge clock);
    check("reset_line", int'(outgoing_line), 0);
    check("reset_ready", int'(in_ready), 1);
    reset_n = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 8; i++) begin
      send(vecs[i].value);
      measure(w);
      check($sformatf("width_v%0d", vecs[i].value), w, vecs[i].width);
      check("ready_at_done", int'(in_ready), 0);
      repeat (GAP) @(negedge clock);
      check("ready_after_gap", int'(in_ready), 1);
`ifdef PULSE_ENCODER_RANGE_ERR_EN
      check("range_err_sticky", int'(range_err), vecs[i].rerr);
`endif
    end

    // in_valid held high across three values; each must wait for in_ready.
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      int n;
      in_value = VW'(seq_vals[i]);
      n = 0;
      while (!in_ready && n < 60) begin
        @(negedge clock);
        n++;
      end
      if (n >= 60) check("hold_timeout", 0, 1);
      @(negedge clock);
    end
    in_valid = 1'b0;
    wait_idle();
    check("hold_pending", exp_q.size(), 0);

    // Asynchronous reset on the third high cycle of a six-cycle pulse.
    send(2);
    repeat (2) @(negedge clock);
    check("pre_reset_line", int'(outgoing_line), 1);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_line", int'(outgoing_line), 0);
    check("async_reset_done", int'(done), 0);
    @(negedge clock);
    check("reset_ready", int'(in_ready), 1);
    reset_n = 1'b1;
    @(negedge clock);
    send(4);
    measure(w);
    check("width_after_reset", w, 4);
    wait_idle();

    // Random sweep; the model and loopback receiver check every cycle.
    repeat (800) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_value = VW'($urandom_range(0, 15));
      @(negedge clock);
    end
    in_valid = 1'b0;
    wait_idle();
    check("random_pending", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
